usr_shift_nbit: RTL and testbench

- Parametrised universal shift register; successor to the 4-bit SISO bidirectional shifter.
- Generalised to WIDTH bits; adds parallel load/read, rotate, clear, and a burst controller that shifts a programmed number of positions under a start/busy/done handshake.
- Used as the generic serialiser/deserialiser and bit-manipulation stage in lab designs.

---
 rtl/usr_shift_nbit.sv | 151 +++++++++++++++
 tb/tb_usr_shift_nbit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_nbit.sv
// Parametrised universal shift register with shift/rotate/load/clear and a counted burst controller.
// Optional macro USR_SHIFT_PARITY_EN adds a combinational parity output (XOR reduction of q).
module usr_shift_nbit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
`ifdef USR_SHIFT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       mode_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [2:0]       step_mode;
    logic             msb_fill;
    logic             lsb_fill;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] q_next;
    logic             start_shift;

    // During a burst the latched mode drives the datapath; otherwise the live mode does.
    assign step_mode = (state_reg == ST_BURST) ? mode_reg : mode;
    assign msb_fill  = (step_mode == MODE_ROR) ? q_reg[0] : sin_l;
    assign lsb_fill  = (step_mode == MODE_ROL) ? q_reg[WIDTH-1] : sin_r;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_neighbour
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_vec[gi] = msb_fill;
            end else begin : g_mid_r
                assign shr_vec[gi] = q_reg[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = lsb_fill;
            end else begin : g_mid_l
                assign shl_vec[gi] = q_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        case (step_mode)
            MODE_SHR, MODE_ROR: q_next = shr_vec;
            MODE_SHL, MODE_ROL: q_next = shl_vec;
            MODE_LOAD:          q_next = pdata;
            MODE_CLEAR:         q_next = '0;
            default:            q_next = q_reg;
        endcase
    end

    assign start_shift = start && (mode >= MODE_SHR) && (mode <= MODE_ROL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            mode_reg  <= MODE_HOLD;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start_shift) begin
                        // Accepting a burst consumes this edge; shifting begins next edge.
                        mode_reg <= mode;
                        cnt_reg  <= count;
                        if (count != '0) begin
                            state_reg <= ST_BURST;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        q_reg <= q_next;
                    end
                end
                ST_BURST: begin
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = q_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];
    assign busy   = busy_reg;
    assign done   = done_reg;

`ifdef USR_SHIFT_PARITY_EN
    assign parity = ^q_reg;
`endif

endmodule

// File: tb/tb_usr_shift_nbit.sv
// Directed self-checking bench for usr_shift_nbit (WIDTH=4, CNT_W=4).
module tb_usr_shift_nbit;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] pdata;
    logic       start;
    logic [3:0] count;
    logic [3:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;
`ifdef USR_SHIFT_PARITY_EN
    logic       parity;
`endif

    int checks_cnt;
    int errors_cnt;

    usr_shift_nbit #(.WIDTH(4), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .pdata  (pdata),
        .start  (start),
        .count  (count),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
`ifdef USR_SHIFT_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before anything is sampled or driven.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst   = 1'b0;
        mode  = 3'b101;
        pdata = 4'hF;
        start = 1'b0;
        count = 4'd0;
        sin_l = 1'b0;
        sin_r = 1'b0;

        // Reset held with a load pending
        tick; tick;
        check("rst_q", q, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        tick;
        check("load_after_rst", q, 4'hF);

        // Legacy SISO right-shift sequence
        mode = 3'b110; tick;
        check("clear", q, 4'b0000);
        mode = 3'b001; sin_l = 1'b1; tick;
        check("shr1", q, 4'b1000);
        sin_l = 1'b0; tick;
        check("shr2", q, 4'b0100);
        tick;
        check("shr3", q, 4'b0010);
        tick;
        check("shr4", q, 4'b0001);
        check("sout_r", sout_r, 1'b1);
        check("sout_l", sout_l, 1'b0);
        mode = 3'b010; sin_r = 1'b1; tick;
        check("shl", q, 4'b0011);
        mode = 3'b000; tick;
        check("hold", q, 4'b0011);

        // Rotates
        mode = 3'b101; pdata = 4'b1001; tick;
        check("load_1001", q, 4'b1001);
        mode = 3'b011; tick;
        check("ror1", q, 4'b1100);
        tick;
        check("ror2", q, 4'b0110);
        tick;
        check("ror3", q, 4'b0011);
        mode = 3'b100; tick;
        check("rol1", q, 4'b0110);
        mode = 3'b111; tick;
        check("reserved_hold", q, 4'b0110);

        // Burst: shift left 3 with sin_r=0, mode changed while busy
        mode = 3'b101; pdata = 4'b1011; tick;
        check("load_1011", q, 4'b1011);
        start = 1'b1; mode = 3'b010; count = 4'd3; sin_r = 1'b0; tick;
        check("b_accept_q", q, 4'b1011);
        check("b_accept_busy", busy, 1'b1);
        start = 1'b0; mode = 3'b101; pdata = 4'hF; tick;
        check("b_step1_q", q, 4'b0110);
        check("b_step1_busy", busy, 1'b1);
        tick;
        check("b_step2_q", q, 4'b1100);
        check("b_step2_busy", busy, 1'b1);
        tick;
        check("b_step3_q", q, 4'b1000);
        check("b_step3_busy", busy, 1'b0);
        check("b_done", done, 1'b1);

        // Start during DONE is ignored; accepted on the following edge
        start = 1'b1; mode = 3'b010; count = 4'd2; sin_r = 1'b1; tick;
        check("done_ign_q", q, 4'b1000);
        check("done_ign_busy", busy, 1'b0);
        check("done_ign_done", done, 1'b0);
        tick;
        check("b2_accept_busy", busy, 1'b1);
        check("b2_accept_q", q, 4'b1000);
        start = 1'b0; mode = 3'b000; tick;
        check("b2_step1_q", q, 4'b0001);
        tick;
        check("b2_step2_q", q, 4'b0011);
        check("b2_done", done, 1'b1);
        tick;
        check("b2_done_clr", done, 1'b0);

        // count=0: done pulse, no busy, no shift
        start = 1'b1; mode = 3'b010; count = 4'd0; tick;
        check("c0_q", q, 4'b0011);
        check("c0_busy", busy, 1'b0);
        check("c0_done", done, 1'b1);
        start = 1'b0; mode = 3'b000; tick;
        check("c0_done_clr", done, 1'b0);
        check("c0_busy2", busy, 1'b0);

        // start with a non-shift mode is a plain load
        start = 1'b1; mode = 3'b101; pdata = 4'b1010; count = 4'd3; tick;
        check("sl_q", q, 4'b1010);
        check("sl_busy", busy, 1'b0);
        check("sl_done", done, 1'b0);
        start = 1'b0; mode = 3'b000;

        // Asynchronous reset in the 2nd cycle of a count=5 burst
        start = 1'b1; mode = 3'b001; count = 4'd5; sin_l = 1'b0; tick;
        check("r_accept_busy", busy, 1'b1);
        start = 1'b0; tick;
        check("r_step1_q", q, 4'b0101);
        #2 rst = 1'b0;
        #1;
        check("r_async_q", q, 4'h0);
        check("r_async_busy", busy, 1'b0);
        tick;
        check("r_hold_done", done, 1'b0);
        tick;
        check("r_hold_q", q, 4'h0);
        mode = 3'b000; rst = 1'b1; tick;
        check("r_rel_q", q, 4'h0);
        check("r_rel_busy", busy, 1'b0);
        check("r_rel_done", done, 1'b0);
        tick;
        check("r_after_done", done, 1'b0);

`ifdef USR_SHIFT_PARITY_EN
        mode = 3'b101; pdata = 4'b1011; tick;
        check("parity_1011", parity, 1'b1);
        pdata = 4'b0110; tick;
        check("parity_0110", parity, 1'b0);
        mode = 3'b000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
